// File: rtl/traffic_pkg.sv
// Shared constants for the intersection phase controller: lamp codes, phase codes, lamp decode.
// Latency: n/a (package only).
// Backpressure: n/a.
package traffic_pkg;

    localparam int PHASE_W = 3;

    typedef logic [0:2]         light_t;
    typedef logic [PHASE_W-1:0] phase_t;

    // Lamp encoding, bit 0 = red, bit 1 = green, bit 2 = yellow
    localparam light_t RED    = 3'b100;
    localparam light_t GREEN  = 3'b010;
    localparam light_t YELLOW = 3'b001;

    localparam phase_t ST_MAIN_G   = 3'd0;
    localparam phase_t ST_MAIN_Y   = 3'd1;
    localparam phase_t ST_ALL_R1   = 3'd2;
    localparam phase_t ST_SIDE_G   = 3'd3;
    localparam phase_t ST_SIDE_Y   = 3'd4;
    localparam phase_t ST_ALL_R2   = 3'd5;
    localparam phase_t ST_PED_WALK = 3'd6;

    // Main lamp is only ever non-red in MAIN_G / MAIN_Y; anything else (incl. illegal codes) is red
    function automatic light_t main_lamp(input phase_t s);
        case (s)
            ST_MAIN_G: return GREEN;
            ST_MAIN_Y: return YELLOW;
            default:   return RED;
        endcase
    endfunction

    // Side lamp is only ever non-red in SIDE_G / SIDE_Y
    function automatic light_t side_lamp(input phase_t s);
        case (s)
            ST_SIDE_G: return GREEN;
            ST_SIDE_Y: return YELLOW;
            default:   return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_timer.sv
// Loadable saturating down-counter used as the phase timer; done is high while the count is 0.
// Latency: load takes effect on the next edge; done is combinational from the count register.
// Backpressure: none; load has priority over the decrement.
module phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Count down to zero and hold there until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road timed phase controller (main rests green, latched side/ped requests divert it); optional walk phase under PED_WALK_EN.
// Latency: all outputs registered, changing on the same edge as the state; a latched request acts one edge later.
// Backpressure: none; side_req/ped_req are sampled every cycle into set-priority pending latches.
module traffic_phase_ctrl #(
    parameter int GREEN_MAIN_MIN = 8,
    parameter int GREEN_SIDE     = 6,
    parameter int YELLOW_T       = 3,
    parameter int ALLRED_T       = 1,
    parameter int WALK_T         = 5,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [0:2] main_light,
    output logic [0:2] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    import traffic_pkg::*;

    phase_t           state;
    phase_t           state_nx;
    logic             side_pend;
    logic             ped_go;
    logic             timer_load;
    logic             timer_done;
    logic [CNT_W-1:0] timer_val;
    light_t           main_nx;
    light_t           side_nx;

`ifdef PED_WALK_EN
    logic ped_pend;
    logic walk_nx;
    assign ped_go = ped_pend;
`else
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
    assign ped_go         = 1'b0;
`endif

    // Timer reload value for the state being entered; illegal codes recover through ALL_R2
    function automatic logic [CNT_W-1:0] dur_m1(input phase_t s);
        case (s)
            ST_MAIN_G:   return CNT_W'(GREEN_MAIN_MIN - 1);
            ST_MAIN_Y:   return CNT_W'(YELLOW_T - 1);
            ST_ALL_R1:   return CNT_W'(ALLRED_T - 1);
            ST_SIDE_G:   return CNT_W'(GREEN_SIDE - 1);
            ST_SIDE_Y:   return CNT_W'(YELLOW_T - 1);
            ST_PED_WALK: return CNT_W'(WALK_T - 1);
            default:     return CNT_W'(ALLRED_T - 1);
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_MAIN_G;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: every phase waits for the timer; MAIN_G additionally waits for a pending request
    always_comb begin
        state_nx = state;
        case (state)
            ST_MAIN_G: if (timer_done && (side_pend || ped_go)) state_nx = ST_MAIN_Y;
            ST_MAIN_Y: if (timer_done) state_nx = ST_ALL_R1;
            ST_ALL_R1: if (timer_done) state_nx = ped_go ? ST_PED_WALK : ST_SIDE_G;
            ST_SIDE_G: if (timer_done) state_nx = ST_SIDE_Y;
            ST_SIDE_Y: if (timer_done) state_nx = ST_ALL_R2;
            ST_ALL_R2: if (timer_done) state_nx = ST_MAIN_G;
`ifdef PED_WALK_EN
            ST_PED_WALK: if (timer_done) state_nx = side_pend ? ST_SIDE_G : ST_ALL_R2;
`endif
            default:   state_nx = ST_ALL_R2;
        endcase
    end

    // Output decode from the next state so the registered lamps move with the state
    always_comb begin
        main_nx = main_lamp(state_nx);
        side_nx = side_lamp(state_nx);
`ifdef PED_WALK_EN
        walk_nx = (state_nx == ST_PED_WALK);
`endif
    end

    // Registered lamp outputs; reset shows main green / side red immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_light <= GREEN;
            side_light <= RED;
        end else begin
            main_light <= main_nx;
            side_light <= side_nx;
        end
    end

    assign phase = state;

    // Side request latch: cleared on entry to SIDE_G, but a request on that same edge wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_pend <= 1'b0;
        end else begin
            side_pend <= side_req | (side_pend & ~((state_nx == ST_SIDE_G) && (state != ST_SIDE_G)));
        end
    end

`ifdef PED_WALK_EN
    // Pedestrian latch and walk lamp: cleared on entry to PED_WALK, set wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            ped_pend <= ped_req | (ped_pend & ~((state_nx == ST_PED_WALK) && (state != ST_PED_WALK)));
            walk     <= walk_nx;
        end
    end
`else
    assign walk = 1'b0;
`endif

    assign timer_load = (state_nx != state);
    assign timer_val  = dur_m1(state_nx);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(GREEN_MAIN_MIN - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: phase-duration reference model checked every cycle plus literal timing pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_phase_ctrl;

    localparam int D_MG = 8;
    localparam int D_SG = 6;
    localparam int D_Y  = 3;
    localparam int D_AR = 1;
    localparam int D_W  = 5;
`ifdef PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam logic [0:2] L_RED = 3'b100;
    localparam logic [0:2] L_GRN = 3'b010;
    localparam logic [0:2] L_YEL = 3'b001;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req  = 1'b0;
    logic [0:2] main_light;
    logic [0:2] side_light;
    logic       walk;
    logic [2:0] phase;

    traffic_phase_ctrl #(
        .GREEN_MAIN_MIN (D_MG),
        .GREEN_SIDE     (D_SG),
        .YELLOW_T       (D_Y),
        .ALLRED_T       (D_AR),
        .WALK_T         (D_W),
        .CNT_W          (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: phase + cycles spent in it ----------------
    int m_phase = 0;
    int m_cnt   = 1;
    bit m_side  = 1'b0;
    bit m_ped   = 1'b0;
    bit chk_en  = 1'b0;
    int m_nxt;
    bit m_done;

    function automatic int dur(input int p);
        case (p)
            0:       return D_MG;
            1, 4:    return D_Y;
            3:       return D_SG;
            6:       return D_W;
            default: return D_AR;
        endcase
    endfunction

    function automatic logic [0:2] exp_main(input int p);
        if (p == 0) return L_GRN;
        if (p == 1) return L_YEL;
        return L_RED;
    endfunction

    function automatic logic [0:2] exp_side(input int p);
        if (p == 3) return L_GRN;
        if (p == 4) return L_YEL;
        return L_RED;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0;
            m_cnt   = 1;
            m_side  = 1'b0;
            m_ped   = 1'b0;
        end else begin
            m_done = (m_cnt >= dur(m_phase));
            m_nxt  = m_phase;
            if (m_done) begin
                case (m_phase)
                    0: if (m_side || (PED && m_ped)) m_nxt = 1;
                    1: m_nxt = 2;
                    2: m_nxt = (PED && m_ped) ? 6 : 3;
                    3: m_nxt = 4;
                    4: m_nxt = 5;
                    5: m_nxt = 0;
                    6: m_nxt = m_side ? 3 : 5;
                    default: m_nxt = 5;
                endcase
            end
            m_side = side_req || (m_side && !(m_nxt == 3 && m_phase != 3));
            m_ped  = PED && (ped_req || (m_ped && !(m_nxt == 6 && m_phase != 6)));
            if (m_nxt != m_phase) m_cnt = 1;
            else if (m_cnt < 1000) m_cnt = m_cnt + 1;
            m_phase = m_nxt;
            #1;
            if (!rst && chk_en) begin
                check("phase", phase, m_phase);
                check("main_light", main_light, exp_main(m_phase));
                check("side_light", side_light, exp_side(m_phase));
                check("walk", walk, (PED && m_phase == 6) ? 1 : 0);
                check("both_lamps_nonred", (main_light != L_RED) && (side_light != L_RED), 0);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    int obs [0:40];
    int run;
    int prev;
    bit started;
    bit found;
    int sg_cnt;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one edge's inputs from a negedge, record phase #1 after the edge, return to negedge
    task automatic step(input logic s, input logic p, output int ph);
        side_req = s;
        ped_req  = p;
        @(posedge clk);
        #1;
        ph = phase;
        @(negedge clk);
    endtask

    initial begin
        int ph;
        repeat (2) @(negedge clk);
        check("rst_main", main_light, L_GRN);
        check("rst_side", side_light, L_RED);
        check("rst_phase", phase, 0);
        check("rst_walk", walk, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle: main rests green
        for (int e = 1; e <= 40; e++) step(1'b0, 1'b0, ph);
        check("idle_phase", ph, 0);

        // One-cycle side pulse latched on edge 3
        do_reset();
        sg_cnt = 0;
        for (int e = 1; e <= 30; e++) begin
            step(e == 3, 1'b0, obs[e]);
            if (obs[e] == 3) sg_cnt++;
        end
        check("pulse_e7_main_g", obs[7], 0);
        check("pulse_e8_main_y", obs[8], 1);
        check("pulse_e10_main_y", obs[10], 1);
        check("pulse_e11_all_r1", obs[11], 2);
        check("pulse_e12_side_g", obs[12], 3);
        check("pulse_e17_side_g", obs[17], 3);
        check("pulse_e18_side_y", obs[18], 4);
        check("pulse_e21_all_r2", obs[21], 5);
        check("pulse_e22_main_g", obs[22], 0);
        check("pulse_side_g_len", sg_cnt, 6);

        // Side request held high: every re-entered MAIN_G lasts exactly 8 cycles
        do_reset();
        prev = 0;
        started = 1'b0;
        run = 0;
        for (int e = 1; e <= 100; e++) begin
            step(1'b1, 1'b0, ph);
            if (ph == 0 && prev != 0) begin
                started = 1'b1;
                run = 1;
            end else if (ph == 0) begin
                run++;
            end else if (prev == 0 && started) begin
                check("held_main_g_len", run, 8);
            end
            prev = ph;
        end

        // Late request after main minimum green has expired
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step(e == 20, 1'b0, obs[e]);
        end
        check("late_e20_main_g", obs[20], 0);
        check("late_e21_main_y", obs[21], 1);

`ifdef PED_WALK_EN
        // Pedestrian-only request: walk phase, never side green
        do_reset();
        sg_cnt = 0;
        for (int e = 1; e <= 30; e++) begin
            step(1'b0, e == 3, obs[e]);
            if (obs[e] == 3) sg_cnt++;
        end
        check("ped_e8_main_y", obs[8], 1);
        check("ped_e11_all_r1", obs[11], 2);
        check("ped_e12_walk", obs[12], 6);
        check("ped_e16_walk", obs[16], 6);
        check("ped_e17_all_r2", obs[17], 5);
        check("ped_e18_main_g", obs[18], 0);
        check("ped_no_side_g", sg_cnt, 0);
`endif

        // Asynchronous reset in the middle of SIDE_Y
        do_reset();
        found = 1'b0;
        for (int e = 1; e <= 40 && !found; e++) begin
            side_req = (e == 1);
            @(posedge clk);
            #1;
            if (phase == 4) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_side_y", found, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_main", main_light, L_GRN);
        check("arst_side", side_light, L_RED);
        check("arst_phase", phase, 0);
        check("arst_walk", walk, 0);
        check("arst_side_pend", u_dut.side_pend, 0);
`ifdef PED_WALK_EN
        check("arst_ped_pend", u_dut.ped_pend, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        side_req = 1'b0;

        // Randomized traffic with occasional bursts and resets
        for (int e = 0; e < 2000; e++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            if (e % 200 < 30) step(1'b1, $urandom_range(0, 3) == 0, ph);
            else step($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, ph);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
